mem_io_controller: RTL and testbench

Memory/I-O bridge that sits directly upstream of the datapath's In port and downstream of its Address/Out/MIO_EN outputs. It turns a level-held datapath memory request into a timed external SRAM access, or into a single-cycle access to the memory-mapped switch/hex I/O word. It returns read data on Data_CPU_Out and signals completion with a one-cycle R pulse that the control unit waits on.

---
 rtl/mem_io_controller.sv | 115 +++++++++++
 tb/tb_mem_io_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_io_controller.sv
`default_nettype none
// ============================================================================
// Module   : mem_io_controller
// Purpose  : Bridges a level-held datapath memory request to a timed SRAM
//            access or a single-cycle memory-mapped switch/hex I/O access.
// Revision : 1.0 - initial release
// ============================================================================
module mem_io_controller #(
   parameter int          WAIT_STATES = 2,
   parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        MIO_EN,
   input  logic        WE,
   input  logic [15:0] Address,
   input  logic [15:0] Data_CPU_In,
   output logic [15:0] Data_CPU_Out,
   output logic        R,
   output logic        Busy,
   input  logic [15:0] Switches,
   output logic [15:0] Hex_Out,
   output logic [19:0] SRAM_ADDR,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N,
   output logic [15:0] SRAM_DQ_Out,
   output logic        SRAM_DQ_OE,
   input  logic [15:0] SRAM_DQ_In
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ACCESS  = 2'd1;
   localparam logic [1:0] DONE    = 2'd2;
   localparam logic [1:0] RELEASE = 2'd3;

   localparam logic [3:0] LAST_CNT = 4'(WAIT_STATES - 1);

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic [15:0] addr_q;
   logic        we_q;
   logic [15:0] data_q;
   logic [15:0] dout_q;
   logic [15:0] hex_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         addr_q <= 16'd0;
         we_q   <= 1'b0;
         data_q <= 16'd0;
         dout_q <= 16'd0;
         hex_q  <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               if (MIO_EN) begin
                  addr_q <= Address;
                  we_q   <= WE;
                  data_q <= Data_CPU_In;
                  // The I/O word completes at the accept edge itself.
                  if (Address == IO_ADDR) begin
                     state <= DONE;
                     if (WE) begin
                        hex_q <= Data_CPU_In;
                     end else begin
                        dout_q <= Switches;
                     end
                  end else begin
                     state <= ACCESS;
                     cnt   <= 4'd0;
                  end
               end
            end
            ACCESS: begin
               cnt <= cnt + 4'd1;
               if (cnt == LAST_CNT) begin
                  state <= DONE;
                  if (!we_q) begin
                     dout_q <= SRAM_DQ_In;
                  end
               end
            end
            DONE: begin
               state <= MIO_EN ? RELEASE : IDLE;
            end
            RELEASE: begin
               // Hold off until the level-held request drops so one request
               // yields exactly one access.
               if (!MIO_EN) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign R            = (state == DONE);
   assign Busy         = (state != IDLE);
   assign Data_CPU_Out = dout_q;
   assign Hex_Out      = hex_q;
   assign SRAM_ADDR    = {4'b0000, addr_q};
   assign SRAM_DQ_Out  = data_q;
   assign SRAM_CE_N    = !(state == ACCESS);
   assign SRAM_OE_N    = !((state == ACCESS) && !we_q);
   assign SRAM_WE_N    = !((state == ACCESS) && we_q);
   assign SRAM_DQ_OE   = (state == ACCESS) && we_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_io_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_io_controller
// Purpose  : Directed scoreboard bench for mem_io_controller with SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_io_controller;

   localparam int WS = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        mio_en;
   logic        we;
   logic [15:0] address;
   logic [15:0] data_cpu_in;
   logic [15:0] data_cpu_out;
   logic        r;
   logic        busy;
   logic [15:0] switches;
   logic [15:0] hex_out;
   logic [19:0] sram_addr;
   logic        sram_ce_n;
   logic        sram_oe_n;
   logic        sram_we_n;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] dout;
      logic [15:0] hex;
   } exp_t;
   exp_t exp_q[$];

   logic [15:0] sram_mem [0:65535];

   mem_io_controller #(.WAIT_STATES(WS), .IO_ADDR(16'hFFFF)) dut (
      .Clk          (clk),
      .Reset        (reset),
      .MIO_EN       (mio_en),
      .WE           (we),
      .Address      (address),
      .Data_CPU_In  (data_cpu_in),
      .Data_CPU_Out (data_cpu_out),
      .R            (r),
      .Busy         (busy),
      .Switches     (switches),
      .Hex_Out      (hex_out),
      .SRAM_ADDR    (sram_addr),
      .SRAM_CE_N    (sram_ce_n),
      .SRAM_OE_N    (sram_oe_n),
      .SRAM_WE_N    (sram_we_n),
      .SRAM_DQ_Out  (sram_dq_out),
      .SRAM_DQ_OE   (sram_dq_oe),
      .SRAM_DQ_In   (sram_dq_in)
   );

   always #5 clk = ~clk;

   // SRAM model: location 0x3000 is preloaded with 0xBEEF.
   always_comb begin
      sram_dq_in = 16'h0000;
      if (!sram_oe_n) begin
         sram_dq_in = (sram_addr[15:0] == 16'h3000) ? 16'hBEEF : sram_mem[sram_addr[15:0]];
      end
   end

   always @(posedge clk) begin
      if (!sram_we_n) begin
         sram_mem[sram_addr[15:0]] <= sram_dq_out;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every R pulse pops and checks one expected response.
   always @(negedge clk) begin
      if (r === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_r", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_data_out", {16'd0, data_cpu_out}, {16'd0, e.dout});
            chk("sb_hex_out", {16'd0, hex_out}, {16'd0, e.hex});
         end
      end
   end

   task automatic access(input string tag, input logic [15:0] a, input logic w,
                         input logic [15:0] d, input int hold,
                         input logic [15:0] exp_dout, input logic [15:0] exp_hex,
                         input int exp_r_cyc, input int exp_ce, input int exp_oe,
                         input int exp_we);
      int r_cyc = -1, r_cnt = 0, ce_c = 0, oe_c = 0, we_c = 0, oe_dq_c = 0, bad = 0;
      bit done = 0;
      exp_t e;
      e.dout = exp_dout;
      e.hex  = exp_hex;
      exp_q.push_back(e);
      mio_en = 1'b1; address = a; we = w; data_cpu_in = d;
      for (int c = 1; c <= 60 && !done; c++) begin
         @(negedge clk);
         // Inputs scrambled after accept must be ignored.
         if (c == 1) begin
            address = 16'h7777; we = ~w; data_cpu_in = 16'h5A5A;
         end
         if (!sram_ce_n) begin
            ce_c++;
            if (sram_addr !== {4'h0, a}) bad++;
         end
         if (!sram_oe_n) oe_c++;
         if (!sram_we_n) begin
            we_c++;
            if (sram_dq_out !== d) bad++;
         end
         if (sram_dq_oe) oe_dq_c++;
         if (r) begin
            r_cnt++;
            if (r_cyc < 0) r_cyc = c;
         end
         if (r_cyc >= 0 && c >= hold) mio_en = 1'b0;
         if (r_cyc >= 0 && !mio_en && !busy) done = 1;
      end
      if (!done) chk({tag, "_timeout"}, 32'd1, 32'd0);
      chk({tag, "_r_latency"}, r_cyc, exp_r_cyc);
      chk({tag, "_r_count"}, r_cnt, 32'd1);
      chk({tag, "_ce_cycles"}, ce_c, exp_ce);
      chk({tag, "_oe_cycles"}, oe_c, exp_oe);
      chk({tag, "_we_cycles"}, we_c, exp_we);
      chk({tag, "_dq_oe_cycles"}, oe_dq_c, exp_we);
      chk({tag, "_addr_data_bad"}, bad, 32'd0);
      mio_en = 1'b0;
   endtask

   initial begin
      reset = 1'b1; mio_en = 1'b0; we = 1'b0; address = 16'h0;
      data_cpu_in = 16'h0; switches = 16'h0000;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_r", r, 0);
      chk("rst_dout", data_cpu_out, 0);
      chk("rst_hex", hex_out, 0);
      chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
      @(negedge clk);

      access("sram_rd", 16'h3000, 1'b0, 16'h0000, 0, 16'hBEEF, 16'h0000, WS + 1, WS, WS, 0);
      access("sram_wr", 16'h0042, 1'b1, 16'h1234, 0, 16'hBEEF, 16'h0000, WS + 1, WS, 0, WS);
      access("io_wr", 16'hFFFF, 1'b1, 16'hA5A5, 0, 16'hBEEF, 16'hA5A5, 1, 0, 0, 0);
      switches = 16'h00C3;
      access("io_rd", 16'hFFFF, 1'b0, 16'h0000, 0, 16'h00C3, 16'hA5A5, 1, 0, 0, 0);
      access("hold_rd", 16'h0042, 1'b0, 16'h0000, 10, 16'h1234, 16'hA5A5, WS + 1, WS, WS, 0);
      access("reassert_rd", 16'h3000, 1'b0, 16'h0000, 0, 16'hBEEF, 16'hA5A5, WS + 1, WS, WS, 0);

      // Reset during an SRAM write access: no R, everything cleared.
      mio_en = 1'b1; address = 16'h0100; we = 1'b1; data_cpu_in = 16'h9999;
      @(negedge clk);
      chk("abort_in_access", sram_we_n, 0);
      reset = 1'b1; mio_en = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_r", r, 0);
      chk("abort_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
      chk("abort_dout", data_cpu_out, 0);
      chk("abort_hex", hex_out, 0);

      // Reset and request together: the request is not accepted.
      mio_en = 1'b1; address = 16'hFFFF; we = 1'b1; data_cpu_in = 16'h4321;
      @(negedge clk);
      chk("rst_req_busy", busy, 0);
      chk("rst_req_hex", hex_out, 0);
      reset = 1'b0; mio_en = 1'b0;
      repeat (5) @(negedge clk);
      chk("no_pending_expect", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
